// File: rtl/rtlola_multi_aggregate_monitor_pkg.sv
// Shared definitions for the RTLola multi-aggregate monitor.
//   - sizing constants (value width, tick period, window buckets, queue depth)
//   - event_entry_t: one merged queue entry (three values, three new flags, tick)
//   - bucket_t:      one window bucket (sum, count, signed max + valid)
package rtlola_multi_aggregate_monitor_pkg;

    localparam int unsigned DATA_W        = 64;
    localparam int unsigned PERIOD_CYCLES = 500;
    localparam int unsigned NUM_BUCKETS   = 2;
    localparam int unsigned Q_DEPTH       = 4;
    localparam int unsigned NUM_STREAMS   = 3;

    typedef struct packed {
        logic [NUM_STREAMS-1:0][DATA_W-1:0] values;
        logic [NUM_STREAMS-1:0]             new_flag;
        logic                               tick;
    } event_entry_t;

    typedef struct packed {
        logic [DATA_W-1:0]        sum;
        logic [DATA_W-1:0]        count;
        logic signed [DATA_W-1:0] max;
        logic                     max_valid;
    } bucket_t;

endpackage

// File: rtl/rtlola_event_queue.sv
// Synchronous FIFO holding merged monitor event entries.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push, pop     write / read requests (ignored when full / empty)
//   wr_entry      entry written on an accepted push
//   rd_entry      current head entry (valid while !empty)
//   full, empty   occupancy flags
module rtlola_event_queue
    import rtlola_multi_aggregate_monitor_pkg::*;
#(
    parameter int unsigned DEPTH = Q_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  event_entry_t wr_entry,
    output event_entry_t rd_entry,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    event_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign rd_entry = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rtlola_multi_aggregate_monitor.sv
// RTLola runtime monitor: 3 input streams, 3 sliding-window aggregate outputs.
// Input events and periodic ticks are merged into one queue entry; an eval
// stage pops one entry per cycle, updates the current window bucket and on a
// tick emits sum(input_0), count(input_1) and signed max(input_2) over the
// last NUM_BUCKETS periods, then slides the window.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   en                     global enable (freezes all state when 0)
//   input_x, new_input_x   stream values and their new-event flags
//   output_x, output_x_aktv aggregate results and 1-cycle update pulse
//   q_push/_valid, q_pop/_valid, slide_x, enable_inx, enable_outx  debug strobes
module rtlola_multi_aggregate_monitor
    import rtlola_multi_aggregate_monitor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] input_0,
    input  logic [DATA_W-1:0] input_1,
    input  logic [DATA_W-1:0] input_2,
    input  logic              new_input_0,
    input  logic              new_input_1,
    input  logic              new_input_2,
    output logic [DATA_W-1:0] output_0,
    output logic [DATA_W-1:0] output_1,
    output logic [DATA_W-1:0] output_2,
    output logic              output_0_aktv,
    output logic              output_1_aktv,
    output logic              output_2_aktv,
    output logic              q_push,
    output logic              q_pop,
    output logic              q_push_valid,
    output logic              q_pop_valid,
    output logic              slide_0,
    output logic              slide_1,
    output logic              slide_2,
    output logic              enable_in0,
    output logic              enable_in1,
    output logic              enable_in2,
    output logic              enable_out0,
    output logic              enable_out1,
    output logic              enable_out2
);

    localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);

    logic [CNT_W-1:0]         tick_cnt;
    logic                     tick_due;
    event_entry_t             push_entry;
    event_entry_t             q_head;
    logic                     q_full;
    logic                     q_empty;
    event_entry_t             eval_entry;
    logic                     eval_valid;
    logic                     eval_active;
    logic                     aktv;
    bucket_t                  buckets [NUM_BUCKETS];
    bucket_t                  cur_upd;
    logic [DATA_W-1:0]        agg_sum;
    logic [DATA_W-1:0]        agg_count;
    logic signed [DATA_W-1:0] agg_max;
    logic                     agg_max_valid;

    // ---------------- periodic timer ----------------
    assign tick_due = en & (tick_cnt == CNT_W'(PERIOD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= tick_due ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // ---------------- event merge and queue ----------------
    assign push_entry.values   = {input_2, input_1, input_0};
    assign push_entry.new_flag = {new_input_2, new_input_1, new_input_0};
    assign push_entry.tick     = tick_due;

    assign q_push       = en & (new_input_0 | new_input_1 | new_input_2 | tick_due);
    assign q_push_valid = q_push & ~q_full;
    assign q_pop        = en & ~q_empty;

    rtlola_event_queue #(
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .pop      (q_pop),
        .wr_entry (push_entry),
        .rd_entry (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

    // ---------------- eval stage register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eval_valid <= 1'b0;
            eval_entry <= '0;
        end else if (en) begin
            eval_valid <= q_pop;
            if (q_pop) eval_entry <= q_head;
        end
    end

    // A held entry is only acted upon (and strobed) while enabled.
    assign eval_active = en & eval_valid;

    assign q_pop_valid = eval_active;
    assign enable_in0  = eval_active & eval_entry.new_flag[0];
    assign enable_in1  = eval_active & eval_entry.new_flag[1];
    assign enable_in2  = eval_active & eval_entry.new_flag[2];
    assign enable_out0 = eval_active & eval_entry.tick;
    assign enable_out1 = eval_active & eval_entry.tick;
    assign enable_out2 = eval_active & eval_entry.tick;
    assign slide_0     = eval_active & eval_entry.tick;
    assign slide_1     = eval_active & eval_entry.tick;
    assign slide_2     = eval_active & eval_entry.tick;

    // ---------------- bucket update and aggregation ----------------
    // Current bucket with this entry's inputs folded in; the aggregate is
    // taken over this updated bucket plus all older ones.
    always_comb begin
        cur_upd = buckets[0];
        if (eval_entry.new_flag[0]) begin
            cur_upd.sum = cur_upd.sum + eval_entry.values[0];
        end
        if (eval_entry.new_flag[1]) begin
            cur_upd.count = cur_upd.count + DATA_W'(1);
        end
        if (eval_entry.new_flag[2]) begin
            if (!cur_upd.max_valid || ($signed(eval_entry.values[2]) > cur_upd.max)) begin
                cur_upd.max = $signed(eval_entry.values[2]);
            end
            cur_upd.max_valid = 1'b1;
        end

        agg_sum       = cur_upd.sum;
        agg_count     = cur_upd.count;
        agg_max       = cur_upd.max;
        agg_max_valid = cur_upd.max_valid;
        for (int unsigned i = 1; i < NUM_BUCKETS; i++) begin
            agg_sum   = agg_sum + buckets[i].sum;
            agg_count = agg_count + buckets[i].count;
            if (buckets[i].max_valid && (!agg_max_valid || (buckets[i].max > agg_max))) begin
                agg_max = buckets[i].max;
            end
            agg_max_valid = agg_max_valid | buckets[i].max_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_BUCKETS; i++) begin
                buckets[i] <= '0;
            end
            output_0 <= '0;
            output_1 <= '0;
            output_2 <= '0;
            aktv     <= 1'b0;
        end else begin
            aktv <= eval_active & eval_entry.tick;
            if (eval_active) begin
                if (eval_entry.tick) begin
                    output_0 <= agg_sum;
                    output_1 <= agg_count;
                    output_2 <= agg_max_valid ? agg_max : '0;
                    // Slide: updated current bucket ages, oldest is dropped.
                    buckets[0] <= '0;
                    for (int unsigned i = 1; i < NUM_BUCKETS; i++) begin
                        buckets[i] <= (i == 1) ? cur_upd : buckets[i-1];
                    end
                end else begin
                    buckets[0] <= cur_upd;
                end
            end
        end
    end

    assign output_0_aktv = aktv;
    assign output_1_aktv = aktv;
    assign output_2_aktv = aktv;

endmodule

// File: tb/tb_rtlola_multi_aggregate_monitor.sv
module tb_rtlola_multi_aggregate_monitor;

    localparam int PER = 500;
    localparam int NB  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b1;
    logic [63:0] input_0 = '0, input_1 = '0, input_2 = '0;
    logic        new_input_0 = 1'b0, new_input_1 = 1'b0, new_input_2 = 1'b0;
    logic [63:0] output_0, output_1, output_2;
    logic        output_0_aktv, output_1_aktv, output_2_aktv;
    logic        q_push, q_pop, q_push_valid, q_pop_valid;
    logic        slide_0, slide_1, slide_2;
    logic        enable_in0, enable_in1, enable_in2;
    logic        enable_out0, enable_out1, enable_out2;

    rtlola_multi_aggregate_monitor dut (
        .clk(clk), .rst(rst), .en(en),
        .input_0(input_0), .input_1(input_1), .input_2(input_2),
        .new_input_0(new_input_0), .new_input_1(new_input_1), .new_input_2(new_input_2),
        .output_0(output_0), .output_1(output_1), .output_2(output_2),
        .output_0_aktv(output_0_aktv), .output_1_aktv(output_1_aktv), .output_2_aktv(output_2_aktv),
        .q_push(q_push), .q_pop(q_pop), .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
        .slide_0(slide_0), .slide_1(slide_1), .slide_2(slide_2),
        .enable_in0(enable_in0), .enable_in1(enable_in1), .enable_in2(enable_in2),
        .enable_out0(enable_out0), .enable_out1(enable_out1), .enable_out2(enable_out2)
    );

    always #5 clk = ~clk;

    // Reference model: every input event tagged with the period it fell in.
    typedef struct {
        int                 period;
        logic signed [63:0] val;
    } ev_t;

    // Per-cycle expectation record (cycle k); strobes appear 2 cycles later,
    // aktv/outputs 3 cycles later.
    typedef struct {
        logic        tick;
        logic        push;
        logic [2:0]  nw;
        logic [63:0] o0, o1, o2;
    } rec_t;

    ev_t         ev0[$], ev1[$], ev2[$];
    rec_t        pipe [3];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          aktv_seen = 0;
    logic [63:0] held0, held1, held2;
    logic [63:0] obs0, obs1, obs2;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_out(input int p, output logic [63:0] s, output logic [63:0] c,
                             output logic [63:0] m);
        logic signed [63:0] mx;
        bit any;
        s = '0; c = '0; mx = '0; any = 0;
        foreach (ev0[i]) if (ev0[i].period > p - NB && ev0[i].period <= p) s = s + ev0[i].val;
        foreach (ev1[i]) if (ev1[i].period > p - NB && ev1[i].period <= p) c = c + 64'd1;
        foreach (ev2[i]) begin
            if (ev2[i].period > p - NB && ev2[i].period <= p) begin
                if (!any || ev2[i].val > mx) mx = ev2[i].val;
                any = 1;
            end
        end
        m = any ? mx : '0;
    endtask

    task automatic clear_model();
        ev0.delete(); ev1.delete(); ev2.delete();
        for (int i = 0; i < 3; i++) pipe[i] = '{tick: 1'b0, push: 1'b0, nw: 3'b0, o0: '0, o1: '0, o2: '0};
        held0 = '0; held1 = '0; held2 = '0;
        cyc = 0;
    endtask

    // Called at a negedge: drive one cycle, check, return at the next negedge.
    task automatic step(input logic [2:0] nw, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c);
        rec_t r;
        logic tk;
        input_0 = a; input_1 = b; input_2 = c;
        new_input_0 = nw[0]; new_input_1 = nw[1]; new_input_2 = nw[2];
        tk = ((cyc % PER) == PER - 1);
        #1;
        checks++;
        if (q_push !== ((|nw) | tk)) begin
            failures++; $display("FAIL q_push cyc=%0d got %b expected %b", cyc, q_push, (|nw) | tk);
        end
        checks++;
        if (q_push_valid !== ((|nw) | tk)) begin
            failures++; $display("FAIL q_push_valid cyc=%0d got %b expected %b", cyc, q_push_valid, (|nw) | tk);
        end
        if (nw[0]) ev0.push_back('{period: cyc / PER, val: a});
        if (nw[1]) ev1.push_back('{period: cyc / PER, val: b});
        if (nw[2]) ev2.push_back('{period: cyc / PER, val: c});
        r.tick = tk; r.push = (|nw) | tk; r.nw = nw;
        r.o0 = '0; r.o1 = '0; r.o2 = '0;
        if (tk) model_out(cyc / PER, r.o0, r.o1, r.o2);
        cyc++;
        @(posedge clk);
        @(negedge clk);
        pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = r;
        checks++;
        if (q_pop !== pipe[0].push) begin
            failures++; $display("FAIL q_pop cyc=%0d got %b expected %b", cyc, q_pop, pipe[0].push);
        end
        checks++;
        if (q_pop_valid !== pipe[1].push) begin
            failures++; $display("FAIL q_pop_valid cyc=%0d got %b expected %b", cyc, q_pop_valid, pipe[1].push);
        end
        checks++;
        if ({enable_in2, enable_in1, enable_in0} !== pipe[1].nw) begin
            failures++; $display("FAIL enable_in cyc=%0d got %b expected %b", cyc,
                                 {enable_in2, enable_in1, enable_in0}, pipe[1].nw);
        end
        checks++;
        if ({slide_2, slide_1, slide_0} !== {3{pipe[1].tick}}) begin
            failures++; $display("FAIL slide cyc=%0d got %b expected %b", cyc,
                                 {slide_2, slide_1, slide_0}, {3{pipe[1].tick}});
        end
        checks++;
        if ({enable_out2, enable_out1, enable_out0} !== {3{pipe[1].tick}}) begin
            failures++; $display("FAIL enable_out cyc=%0d got %b expected %b", cyc,
                                 {enable_out2, enable_out1, enable_out0}, {3{pipe[1].tick}});
        end
        checks++;
        if ({output_2_aktv, output_1_aktv, output_0_aktv} !== {3{pipe[2].tick}}) begin
            failures++; $display("FAIL aktv cyc=%0d got %b expected %b", cyc,
                                 {output_2_aktv, output_1_aktv, output_0_aktv}, {3{pipe[2].tick}});
        end
        if (pipe[2].tick) begin
            held0 = pipe[2].o0; held1 = pipe[2].o1; held2 = pipe[2].o2;
            aktv_seen++;
            obs0 = output_0; obs1 = output_1; obs2 = output_2;
        end
        checks++;
        if ({output_2, output_1, output_0} !== {held2, held1, held0}) begin
            failures++; $display("FAIL outputs cyc=%0d got %h/%h/%h expected %h/%h/%h", cyc,
                                 output_0, output_1, output_2, held0, held1, held2);
        end
    endtask

    task automatic idle();
        step(3'b000, rand64(), rand64(), rand64());
    endtask

    // Step through the next tick cycle and the two cycles until aktv is seen.
    task automatic run_to_tick();
        int n;
        n = PER - 1 - (cyc % PER);
        repeat (n + 1) idle();
        idle();
        idle();
    endtask

    task automatic check_obs(input string name, input logic [63:0] e0, input logic [63:0] e1,
                             input logic [63:0] e2);
        checks++;
        if ({obs0, obs1, obs2} !== {e0, e1, e2}) begin
            failures++; $display("FAIL %s got %h/%h/%h expected %h/%h/%h", name, obs0, obs1, obs2, e0, e1, e2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({output_0, output_1, output_2} !== 192'd0) begin
            failures++; $display("FAIL reset_outputs got %h/%h/%h expected 0", output_0, output_1, output_2);
        end
        checks++;
        if ({output_0_aktv, q_pop, q_pop_valid, slide_0, enable_out0, enable_in0} !== 6'b0) begin
            failures++; $display("FAIL reset_strobes got %b expected 0",
                                 {output_0_aktv, q_pop, q_pop_valid, slide_0, enable_out0, enable_in0});
        end
        rst = 1'b1;
        clear_model();
    endtask

    task automatic test_first_tick();
        aktv_seen = 0;
        run_to_tick();
        checks++;
        if (aktv_seen !== 1) begin
            failures++; $display("FAIL first_tick_aktv_count got %0d expected 1", aktv_seen);
        end
        check_obs("first_tick_outputs", 64'd0, 64'd0, 64'd0);
    endtask

    task automatic test_window();
        step(3'b111, 64'd1, 64'd1, 64'd1);
        idle();
        step(3'b111, 64'd2, 64'd2, 64'd2);
        run_to_tick();
        check_obs("window_tick1", 64'd3, 64'd2, 64'd2);
        run_to_tick();
        check_obs("window_tick2", 64'd3, 64'd2, 64'd2);
        run_to_tick();
        check_obs("window_tick3", 64'd0, 64'd0, 64'd0);
    endtask

    task automatic test_single_stream();
        logic [63:0] p0, p1, p2;
        p0 = held0; p1 = held1; p2 = held2;
        step(3'b010, rand64(), 64'd6, rand64());
        run_to_tick();
        check_obs("single_stream", p0, p1 + 64'd1, p2);
    endtask

    task automatic test_extremes();
        step(3'b001, 64'h7fff_ffff_ffff_ffff, rand64(), rand64());
        step(3'b100, rand64(), rand64(), -64'sd5);
        step(3'b001, 64'd1, rand64(), rand64());
        step(3'b100, rand64(), rand64(), -64'sd3);
        run_to_tick();
        checks++;
        if (obs0 !== 64'h8000_0000_0000_0000) begin
            failures++; $display("FAIL sum_wrap got %h expected %h", obs0, 64'h8000_0000_0000_0000);
        end
        checks++;
        if (obs2 !== 64'hffff_ffff_ffff_fffd) begin
            failures++; $display("FAIL signed_max got %h expected %h", obs2, 64'hffff_ffff_ffff_fffd);
        end
    endtask

    task automatic test_tick_coincident();
        repeat (PER - 1 - (cyc % PER)) idle();
        step(3'b001, 64'd7, rand64(), rand64());
        idle();
        idle();
        checks++;
        if (obs0 !== 64'h8000_0000_0000_0007) begin
            failures++; $display("FAIL tick_coincident got %h expected %h", obs0, 64'h8000_0000_0000_0007);
        end
    endtask

    task automatic test_random();
        logic [2:0]  nw;
        logic [63:0] v [3];
        for (int k = 0; k < 3 * PER; k++) begin
            for (int s = 0; s < 3; s++) begin
                nw[s] = ($urandom_range(0, 7) == 0);
                v[s]  = ($urandom_range(0, 1) == 0) ? rand64() : 64'($signed($urandom_range(0, 200)) - 100);
            end
            step(nw, v[0], v[1], v[2]);
        end
        run_to_tick();
    endtask

    task automatic test_reset_midwindow();
        step(3'b111, rand64(), rand64(), rand64());
        step(3'b111, rand64(), rand64(), rand64());
        new_input_0 = 1'b0; new_input_1 = 1'b0; new_input_2 = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({output_0, output_1, output_2} !== 192'd0) begin
            failures++; $display("FAIL midreset_outputs got %h/%h/%h expected 0", output_0, output_1, output_2);
        end
        checks++;
        if ({q_pop, q_pop_valid, enable_in2, enable_in1, enable_in0, output_0_aktv} !== 6'b0) begin
            failures++; $display("FAIL midreset_strobes got %b expected 0",
                                 {q_pop, q_pop_valid, enable_in2, enable_in1, enable_in0, output_0_aktv});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_model();
        run_to_tick();
        check_obs("after_reset_tick", 64'd0, 64'd0, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        held0 = '0; held1 = '0; held2 = '0;
        obs0 = '0; obs1 = '0; obs2 = '0;
        @(negedge clk);
        test_reset();
        test_first_tick();
        test_window();
        test_single_stream();
        test_extremes();
        test_tick_coincident();
        test_random();
        test_reset_midwindow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
